regfile_dbg_arbiter: RTL and testbench
======================================

Name: regfile_dbg_arbiter

Overview:
Shares the register file's write port and rs1 read port between the pipeline writeback stage and a debug requester.
- A debug access asks the pipeline to halt and waits for it to drain.
- It then performs one read or write through the regfile ports and returns a one-cycle ack.
- Sits between execute/writeback and the regfile instance. The rs2 path passes through untouched.

Parameters:
DRAIN_TIMEOUT, 64, max cycles in HALT_WAIT before the debug access is aborted with error.
CNT_W, 7, width of drain counter; must satisfy 2^CNT_W > DRAIN_TIMEOUT.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_wb_valid  in  1  pipeline writeback valid
i_wb_rd_addr  in  5  pipeline writeback destination
i_wb_rd_data  in  32  pipeline writeback data
i_pipe_rs1_addr  in  5  pipeline rs1 read address
o_pipe_rs1_data  out  32  rs1 data to pipeline (pass-through of i_rf_rs1_data)
o_rf_rd_addr  out  5  to regfile write address (0 = no write)
o_rf_rd_data  out  32  to regfile write data
o_rf_rs1_addr  out  5  to regfile rs1 address
i_rf_rs1_data  in  32  from regfile rs1 data
o_halt_req  out  1  request pipeline stop issuing
i_pipe_drained  in  1  pipeline halted, no writeback in flight
i_dbg_req  in  1  debug request, held until ack
i_dbg_we  in  1  1 = write, 0 = read
i_dbg_addr  in  5  debug register index
i_dbg_wdata  in  32  debug write data
i_dbg_hold  in  1  keep pipeline halted after ack
o_dbg_ack  out  1  one-cycle completion pulse
o_dbg_err  out  1  valid with ack; 1 = drain timeout, no access done
o_dbg_rdata  out  32  read result, valid with ack, held until next ack

Behaviour:
- FSM states: IDLE, HALT_WAIT, ACCESS, ACK, HELD. Reset state is IDLE.
- Output reset values: o_halt_req=0, o_dbg_ack=0, o_dbg_err=0, o_dbg_rdata=0, drain counter=0.
- IDLE:
  - i_dbg_req=1 -> HALT_WAIT, counter cleared.
  - o_halt_req is asserted in every state except IDLE.
- HALT_WAIT:
  - i_pipe_drained=1 -> ACCESS.
  - Otherwise the counter increments. When the counter equals DRAIN_TIMEOUT, next state is ACK with err=1.
  - Drained and timeout in the same cycle: drained wins.
- ACCESS:
  - Read: o_rf_rs1_addr=i_dbg_addr; capture i_rf_rs1_data into o_dbg_rdata at end of cycle.
  - Write: o_rf_rd_addr=i_dbg_addr, o_rf_rd_data=i_dbg_wdata.
  - Next state ACK, err=0.
  - If i_wb_valid=1 during ACCESS (late writeback), the pipeline write takes the port, the debug access stalls in ACCESS, and the read capture is deferred.
- ACK:
  - o_dbg_ack=1 for exactly one cycle.
  - Next state is HELD if i_dbg_hold=1, else IDLE (halt drops the following cycle).
- HELD:
  - o_halt_req stays 1.
  - i_dbg_req=1 -> ACCESS directly (the pipeline is already drained).
  - i_dbg_hold=0 and no req -> IDLE.
  - req and hold-drop in the same cycle: req wins.
- Write-port mux, outside ACCESS (and inside ACCESS when i_wb_valid=1):
  - o_rf_rd_addr = i_wb_valid ? i_wb_rd_addr : 0.
  - o_rf_rd_data = i_wb_rd_data.
- Read-port mux: o_rf_rs1_addr = i_pipe_rs1_addr except in a debug-read ACCESS cycle. o_pipe_rs1_data is always i_rf_rs1_data.
- Combinational read latency: ack arrives 1 cycle after the ACCESS cycle.
- Debug access to x0: write has no effect; read returns 0. Both are acked normally.
- i_dbg_req dropped before ack: the access still completes; ack is issued and ignored.
- i_rst mid-operation returns to IDLE next edge. Halt is released, no ack is issued, and any write in that cycle still reaches the regfile.
- Debug inputs must be stable from req until ack. They are not registered.

Decomposition:
- Shared package regfile_dbg_pkg holds the FSM state enum (dbg_state_t) and the localparam REG_ZERO = 5'd0.
- No sub-module: the FSM, counter and muxes live in one module (about 150-200 RTL lines).

Test Plan:
- Debug read x5=0xDEADBEEF, pipe drains 3 cycles after req -> o_halt_req rises the cycle after req; ack 2 cycles after drained; rdata=0xDEADBEEF, err=0.
- Debug write x7=0x12345678, then pipeline reads x7 after halt release -> o_pipe_rs1_data=0x12345678; o_halt_req low 1 cycle after ack.
- i_pipe_drained held 0, DRAIN_TIMEOUT=64 -> ack with err=1 after 64 counted cycles; no regfile write (o_rf_rd_addr=0 throughout).
- Writeback x3=0xAA forced during ACCESS of a debug write x3=0xBB -> pipeline write first, debug next cycle; final x3=0xBB; ack delayed 1 cycle.
- i_dbg_hold=1, three back-to-back reads x1,x2,x0 -> halt stays high throughout; each ack 2 cycles after its req; x0 read returns 0.
- i_rst asserted in HALT_WAIT -> IDLE next cycle, o_halt_req=0, no ack ever issued.

Source files
------------

// File: rtl/regfile_dbg_pkg.sv
// Shared types for the regfile debug arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_dbg_pkg;

  // Arbiter FSM states.
  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    ACCESS,
    ACK,
    HELD
  } dbg_state_t;

  // x0 is hardwired to zero; used as the "no write" address on the write port.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_dbg_arbiter.sv
// Purpose: shares the regfile write port and rs1 read port between pipeline writeback and a debug requester.
// Latency: ack one cycle after the ACCESS cycle; ACCESS follows drain (or req directly when HELD).
// Backpressure: debug waits for i_pipe_drained (bounded by DRAIN_TIMEOUT); a late writeback stalls ACCESS.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_wb_*                            pipeline writeback (valid, rd addr, rd data)
//   i_pipe_rs1_addr / o_pipe_rs1_data pipeline rs1 read (data is a pass-through)
//   o_rf_rd_*, o_rf_rs1_addr,
//   i_rf_rs1_data                     regfile instance ports (rd addr 0 = no write)
//   o_halt_req, i_pipe_drained        halt handshake with the pipeline
//   i_dbg_*                           debug request, held stable until ack
//   o_dbg_ack/err/rdata               one-cycle completion pulse, error flag, read result
module regfile_dbg_arbiter
  import regfile_dbg_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_W         = 7   // 2**CNT_W must exceed DRAIN_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_valid,
  input  logic [4:0]  i_wb_rd_addr,
  input  logic [31:0] i_wb_rd_data,
  input  logic [4:0]  i_pipe_rs1_addr,
  output logic [31:0] o_pipe_rs1_data,
  output logic [4:0]  o_rf_rd_addr,
  output logic [31:0] o_rf_rd_data,
  output logic [4:0]  o_rf_rs1_addr,
  input  logic [31:0] i_rf_rs1_data,
  output logic        o_halt_req,
  input  logic        i_pipe_drained,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [4:0]  i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  input  logic        i_dbg_hold,
  output logic        o_dbg_ack,
  output logic        o_dbg_err,
  output logic [31:0] o_dbg_rdata
);

  localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(DRAIN_TIMEOUT);

  dbg_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_halt_req;
  logic              r_dbg_ack;
  logic              r_dbg_err;
  logic [31:0]       r_dbg_rdata;

  logic              w_access;
  logic              w_dbg_wr;
  logic              w_dbg_rd_sel;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [31:0]       w_rd_capture;

  assign w_access     = (r_state == ACCESS);
  // A writeback arriving during ACCESS owns the write port; the debug write waits.
  assign w_dbg_wr     = w_access && !i_wb_valid && i_dbg_we;
  // The read address is steered for the whole ACCESS stay so the capture sees
  // the value written by any late writeback in the preceding stall cycle.
  assign w_dbg_rd_sel = w_access && !i_dbg_we;
  assign w_cnt_inc    = r_cnt + CNT_W'(1);
  assign w_rd_capture = (i_dbg_addr == REG_ZERO) ? 32'd0 : i_rf_rs1_data;

  assign o_pipe_rs1_data = i_rf_rs1_data;

  always_comb begin
    o_rf_rd_addr  = i_wb_valid ? i_wb_rd_addr : REG_ZERO;
    o_rf_rd_data  = i_wb_rd_data;
    o_rf_rs1_addr = i_pipe_rs1_addr;
    if (w_dbg_wr) begin
      // x0 falls out naturally: address 0 means no write.
      o_rf_rd_addr = i_dbg_addr;
      o_rf_rd_data = i_dbg_wdata;
    end
    if (w_dbg_rd_sel) begin
      o_rf_rs1_addr = i_dbg_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_halt_req  <= 1'b0;
      r_dbg_ack   <= 1'b0;
      r_dbg_err   <= 1'b0;
      r_dbg_rdata <= '0;
    end else begin
      // ack/err are pulses raised only on the transition into ACK.
      r_dbg_ack <= 1'b0;
      r_dbg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_dbg_req) begin
            r_state    <= HALT_WAIT;
            r_cnt      <= '0;
            r_halt_req <= 1'b1;
          end
        end
        HALT_WAIT: begin
          // Drained is checked first so it wins over a coincident timeout.
          if (i_pipe_drained) begin
            r_state <= ACCESS;
          end else if (w_cnt_inc == CNT_TIMEOUT) begin
            r_state   <= ACK;
            r_cnt     <= w_cnt_inc;
            r_dbg_ack <= 1'b1;
            r_dbg_err <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ACCESS: begin
          if (!i_wb_valid) begin
            r_state   <= ACK;
            r_dbg_ack <= 1'b1;
            if (!i_dbg_we) begin
              r_dbg_rdata <= w_rd_capture;
            end
          end
        end
        ACK: begin
          if (i_dbg_hold) begin
            r_state <= HELD;
          end else begin
            r_state    <= IDLE;
            r_halt_req <= 1'b0;
          end
        end
        HELD: begin
          // Pipeline is already drained, so a new request skips HALT_WAIT.
          if (i_dbg_req) begin
            r_state <= ACCESS;
          end else if (!i_dbg_hold) begin
            r_state    <= IDLE;
            r_halt_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_halt_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_halt_req  = r_halt_req;
  assign o_dbg_ack   = r_dbg_ack;
  assign o_dbg_err   = r_dbg_err;
  assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
module tb_regfile_dbg_arbiter;

  localparam int DRAIN_TIMEOUT = 64;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd_addr;
  logic [31:0] i_wb_rd_data;
  logic [4:0]  i_pipe_rs1_addr;
  logic [31:0] o_pipe_rs1_data;
  logic [4:0]  o_rf_rd_addr;
  logic [31:0] o_rf_rd_data;
  logic [4:0]  o_rf_rs1_addr;
  logic [31:0] i_rf_rs1_data;
  logic        o_halt_req;
  logic        i_pipe_drained;
  logic        i_dbg_req;
  logic        i_dbg_we;
  logic [4:0]  i_dbg_addr;
  logic [31:0] i_dbg_wdata;
  logic        i_dbg_hold;
  logic        o_dbg_ack;
  logic        o_dbg_err;
  logic [31:0] o_dbg_rdata;

  regfile_dbg_arbiter #(.DRAIN_TIMEOUT(DRAIN_TIMEOUT), .CNT_W(7)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wb_valid(i_wb_valid), .i_wb_rd_addr(i_wb_rd_addr), .i_wb_rd_data(i_wb_rd_data),
    .i_pipe_rs1_addr(i_pipe_rs1_addr), .o_pipe_rs1_data(o_pipe_rs1_data),
    .o_rf_rd_addr(o_rf_rd_addr), .o_rf_rd_data(o_rf_rd_data),
    .o_rf_rs1_addr(o_rf_rs1_addr), .i_rf_rs1_data(i_rf_rs1_data),
    .o_halt_req(o_halt_req), .i_pipe_drained(i_pipe_drained),
    .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .i_dbg_hold(i_dbg_hold),
    .o_dbg_ack(o_dbg_ack), .o_dbg_err(o_dbg_err), .o_dbg_rdata(o_dbg_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Regfile instance the arbiter drives (environment, x0 reads as zero).
  logic        rf_clr;
  logic [31:0] rf [32];
  always @(posedge i_clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (o_rf_rd_addr != 5'd0) begin
      rf[o_rf_rd_addr] <= o_rf_rd_data;
    end
  end
  assign i_rf_rs1_data = (o_rf_rs1_addr == 5'd0) ? 32'd0 : rf[o_rf_rs1_addr];

  // Reference architectural register contents.
  logic [31:0] ref_regs [32];

  typedef struct packed {
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Scoreboard monitor: every ack must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_dbg_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_err", {31'd0, o_dbg_err}, {31'd0, e.err});
          if (e.chk_rdata) check("ack_rdata", o_dbg_rdata, e.rdata);
        end
      end
    end
  end

  // One debug access. dly: HALT_WAIT cycles before drain; from_held: issued in HELD;
  // late_wb: a writeback to wa/wd arrives in the first ACCESS cycle.
  task automatic dbg_op(input bit we, input logic [4:0] a, input logic [31:0] wdat,
                        input int dly, input bit hold, input bit from_held,
                        input bit late_wb, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    int   lat;
    bit   got;
    if (late_wb && wa != 5'd0) ref_regs[wa] = wd;
    e.err       = 1'b0;
    e.chk_rdata = !we;
    e.rdata     = 32'd0;
    if (we) begin
      if (a != 5'd0) ref_regs[a] = wdat;
    end else begin
      e.rdata = (a == 5'd0) ? 32'd0 : ref_regs[a];
    end
    exp_q.push_back(e);

    i_dbg_req   = 1'b1;
    i_dbg_we    = we;
    i_dbg_addr  = a;
    i_dbg_wdata = wdat;
    i_dbg_hold  = hold;
    if (!from_held) begin
      tick();
      check("halt_rise", {31'd0, o_halt_req}, 32'd1);
      repeat (dly) tick();
      i_pipe_drained = 1'b1;
    end
    // From here: one edge into ACCESS, one edge into ACK (plus one per stall).
    tick();
    lat = 1;
    check("halt_during_access", {31'd0, o_halt_req}, 32'd1);
    if (late_wb) begin
      i_wb_valid   = 1'b1;
      i_wb_rd_addr = wa;
      i_wb_rd_data = wd;
      #1;
      check("late_wb_owns_port", {27'd0, o_rf_rd_addr}, {27'd0, wa});
      tick();
      lat++;
      i_wb_valid = 1'b0;
    end
    got = 1'b0;
    while (lat < 12 && !got) begin
      tick();
      lat++;
      got = o_dbg_ack;
    end
    check("ack_latency", lat, late_wb ? 3 : 2);
    i_dbg_req = 1'b0;
    tick();
    if (hold) begin
      check("halt_held", {31'd0, o_halt_req}, 32'd1);
    end else begin
      check("halt_drop", {31'd0, o_halt_req}, 32'd0);
      i_pipe_drained = 1'b0;
    end
  endtask

  initial begin
    int  n;
    bit  bad;
    exp_t e;
    i_rst = 1'b1; rf_clr = 1'b1;
    i_wb_valid = 1'b0; i_wb_rd_addr = '0; i_wb_rd_data = '0;
    i_pipe_rs1_addr = '0; i_pipe_drained = 1'b0;
    i_dbg_req = 1'b0; i_dbg_we = 1'b0; i_dbg_addr = '0; i_dbg_wdata = '0; i_dbg_hold = 1'b0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    repeat (3) tick();
    i_rst = 1'b0; rf_clr = 1'b0;

    check("rst_halt", {31'd0, o_halt_req}, 32'd0);
    check("rst_ack", {31'd0, o_dbg_ack}, 32'd0);
    check("rst_err", {31'd0, o_dbg_err}, 32'd0);
    check("rst_rdata", o_dbg_rdata, 32'd0);

    // Random pipeline writebacks populate the regfile.
    for (int c = 0; c < 48; c++) begin
      i_wb_valid   = ($urandom_range(0, 3) != 0);
      i_wb_rd_addr = 5'($urandom_range(0, 31));
      i_wb_rd_data = $urandom;
      if (i_wb_valid && i_wb_rd_addr != 5'd0) ref_regs[i_wb_rd_addr] = i_wb_rd_data;
      tick();
    end
    i_wb_valid = 1'b0;

    // Debug read of x5 = 0xDEADBEEF, drain arrives 3 cycles after req.
    i_wb_valid = 1'b1; i_wb_rd_addr = 5'd5; i_wb_rd_data = 32'hDEADBEEF;
    ref_regs[5] = 32'hDEADBEEF;
    tick();
    i_wb_valid = 1'b0;
    dbg_op(1'b0, 5'd5, 32'd0, 2, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

    // Debug write x7, then the pipeline reads it back after release.
    dbg_op(1'b1, 5'd7, 32'h12345678, 1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    i_pipe_rs1_addr = 5'd7;
    #1;
    check("pipe_read_x7", o_pipe_rs1_data, 32'h12345678);

    // Drain never arrives: error ack after DRAIN_TIMEOUT HALT_WAIT cycles, no write.
    e.err = 1'b1; e.chk_rdata = 1'b0; e.rdata = 32'd0;
    exp_q.push_back(e);
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd9; i_dbg_wdata = 32'hBAD0BAD0; i_dbg_hold = 1'b0;
    n = 0; bad = 1'b0;
    while (n < 200 && !o_dbg_ack) begin
      tick();
      n++;
      if (o_rf_rd_addr != 5'd0) bad = 1'b1;
    end
    // One edge into HALT_WAIT, DRAIN_TIMEOUT cycles there, ack visible after the last.
    check("timeout_ack_cycles", n, DRAIN_TIMEOUT + 1);
    check("timeout_no_write", {31'd0, bad}, 32'd0);
    i_dbg_req = 1'b0;
    tick();
    check("timeout_halt_drop", {31'd0, o_halt_req}, 32'd0);

    // Late writeback x3=0xAA collides with debug write x3=0xBB.
    dbg_op(1'b1, 5'd3, 32'h000000BB, 0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h000000AA);
    i_pipe_rs1_addr = 5'd3;
    #1;
    check("pipe_read_x3", o_pipe_rs1_data, 32'h000000BB);

    // Held halt: back-to-back reads x1, x2, x0.
    dbg_op(1'b0, 5'd1, 32'd0, 1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    dbg_op(1'b0, 5'd2, 32'd0, 0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
    dbg_op(1'b0, 5'd0, 32'd0, 0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);

    // Random debug accesses (including x0 writes).
    for (int k = 0; k < 10; k++) begin
      dbg_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 5), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    end

    // Reset during HALT_WAIT: back to IDLE, halt released, no ack.
    i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd5; i_dbg_hold = 1'b0;
    tick();
    check("rst_test_halt_up", {31'd0, o_halt_req}, 32'd1);
    i_rst = 1'b1;
    tick();
    check("rst_mid_halt", {31'd0, o_halt_req}, 32'd0);
    i_rst = 1'b0;
    i_dbg_req = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (o_dbg_ack) bad = 1'b1;
    end
    check("rst_no_ack", {31'd0, bad}, 32'd0);

    // Whole-regfile sweep through the pipeline read path.
    for (int r = 0; r < 32; r++) begin
      i_pipe_rs1_addr = 5'(r);
      #1;
      check("pipe_sweep", o_pipe_rs1_data, (r == 0) ? 32'd0 : ref_regs[r]);
    end

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
